multi_cycle_core: RTL
=====================

MULTI_CYCLE_CORE -- requirements
Module: multi_cycle_core

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath/register width (32 or 64; instructions always 32 bits).
REQ-002 SHALL have parameter NREGS, default 32, architectural register count (16 or 32).
REQ-003 SHALL have parameter RESET_PC, default 0, PC value loaded at reset.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port mem_req  output  1  memory request valid.
REQ-007 SHALL have port mem_we  output  1  1 = store, 0 = fetch/load.
REQ-008 SHALL have port mem_addr  output  XLEN  request byte address.
REQ-009 SHALL have port mem_wdata  output  XLEN  store data.
REQ-010 SHALL have port mem_rdata  input  XLEN  read data; the instruction is mem_rdata[31:0].
REQ-011 SHALL have port mem_ack  input  1  request completes on the rising edge where mem_req=1 and mem_ack=1.
REQ-012 SHALL have port pc  output  XLEN  current PC, for debug.
REQ-013 SHALL have port halted  output  1  core stopped on an illegal instruction.

Function
REQ-014 SHALL execute the following instructions:
- lw, sw.
- add, sub, and, or, slt (R-type).
- addi.
- beq.
REQ-015 SHALL implement the FSM states FETCH, DECODE, EXEC, MEM, WB and HALT.
REQ-016 FETCH SHALL drive mem_req=1, mem_we=0, mem_addr=pc, latch the instruction on ack, then go to DECODE.
REQ-017 DECODE SHALL read rs1/rs2, sign-extend the I/S/B immediate to XLEN, then go to EXEC, or to HALT if the opcode, funct3 or funct7 is unsupported.
REQ-018 EXEC SHALL branch by instruction type:
- R/addi: compute the ALU result, go to WB.
- lw/sw: compute rs1+imm, go to MEM.
- beq: pc <= (rs1==rs2) ? pc+imm : pc+4, go to FETCH.
REQ-019 MEM SHALL drive mem_req=1, mem_addr=rs1+imm, mem_we=1 for sw with mem_wdata=rs2, and hold all outputs stable until ack.
- On sw ack: pc+=4, go to FETCH.
- On lw ack: capture mem_rdata, go to WB.
REQ-020 WB SHALL write rd (ALU result or load data), set pc+=4, then go to FETCH.
REQ-021 Cycle counts with zero-wait ack SHALL be:
- R-type/addi: 4.
- lw: 5.
- sw: 4.
- beq: 3.
- Each wait cycle in FETCH or MEM adds 1.
REQ-022 mem_req SHALL be 0 in every state except FETCH and MEM; mem_ack seen while mem_req=0 SHALL be ignored.
REQ-023 While mem_req=1 without ack, mem_addr, mem_we and mem_wdata SHALL NOT change.
REQ-024 Register x0 SHALL read 0; writes to x0 SHALL be discarded.
REQ-025 With NREGS=16, any rs1/rs2/rd index >= 16 SHALL be illegal and go to HALT.
REQ-026 Arithmetic and address/PC adds SHALL wrap modulo 2^XLEN; sub SHALL be two's complement; slt SHALL be a signed compare yielding 1 or 0.
REQ-027 Addresses SHALL be passed unaltered, with no alignment check.
REQ-028 HALT SHALL be absorbing: halted=1, mem_req=0, pc frozen at the faulting instruction, and only rst exits it.
REQ-029 A branch target equal to pc SHALL loop legally; it is not treated as a halt.

Reset
REQ-030 While rst=1, outputs SHALL asynchronously be:
- state=FETCH, pc=RESET_PC.
- mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0.
- halted=0, all registers=0.
REQ-031 A reset asserted mid-transaction SHALL drop mem_req immediately with no register or pc update; a pending ack SHALL be ignored.
REQ-032 On the first rising edge after rst deasserts, the core SHALL present a FETCH request at RESET_PC.

Verification
REQ-033 The bench SHALL cover these directed scenarios:
- Zero-wait memory, program addi x1,x0,5; addi x2,x0,-3; add x3,x1,x2 -> x3=2, pc=12 after 12 cycles.
- sub x4,x2,x1 and slt x5,x2,x1 -> x4=0xFFFFFFF8, x5=1.
- sw x1,8(x0), then lw x6,8(x0), with 3 wait cycles per MEM -> mem[8]=5, x6=5; mem_addr/mem_wdata stable during the waits.
- beq x1,x1,-4 -> pc decrements by 4 and loops; beq x1,x2,+8 not taken -> pc+4.
- Opcode 0x7F -> halted=1 after DECODE, mem_req stays 0, pc holds; rst pulse -> pc=RESET_PC, halted=0.
- rst asserted during a FETCH with mem_ack held low, then ack raised -> mem_req=0 immediately, no state change; addi x0,x0,7 -> x0 reads 0.

Source files
------------

// File: rtl/multi_cycle_core_if.sv
// Request/acknowledge memory bus shared by instruction fetch and data access.
// A transfer completes on the rising edge where mem_req and mem_ack are both high.
interface multi_cycle_core_if #(
    parameter int XLEN = 32
);
    logic            mem_req;
    logic            mem_we;
    logic [XLEN-1:0] mem_addr;
    logic [XLEN-1:0] mem_wdata;
    logic [XLEN-1:0] mem_rdata;
    logic            mem_ack;

    modport master (output mem_req, mem_we, mem_addr, mem_wdata, input mem_rdata, mem_ack);
    modport slave  (input mem_req, mem_we, mem_addr, mem_wdata, output mem_rdata, mem_ack);
endinterface

// File: rtl/multi_cycle_core.sv
// Unpipelined RV32I-subset core (lw, sw, add, sub, and, or, slt, addi, beq).
// Runs a FETCH/DECODE/EXEC/MEM/WB state machine over a single shared memory bus.
module multi_cycle_core #(
    parameter int              XLEN     = 32,
    parameter int              NREGS    = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    multi_cycle_core_if.master    bus,
    output logic [XLEN-1:0]       pc,
    output logic                  halted
);
    localparam int RW = $clog2(NREGS);

    localparam logic [2:0] FETCH  = 3'd0;
    localparam logic [2:0] DECODE = 3'd1;
    localparam logic [2:0] EXEC   = 3'd2;
    localparam logic [2:0] MEM    = 3'd3;
    localparam logic [2:0] WB     = 3'd4;
    localparam logic [2:0] HALT   = 3'd5;

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_ADDI = 7'b0010011;
    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;

    localparam logic [XLEN-1:0] FOUR = XLEN'(4);

    logic [2:0]      state;
    logic [XLEN-1:0] pc_q;
    logic [31:0]     ir;
    logic [XLEN-1:0] a_q, b_q, imm_q, res_q;
    logic [XLEN-1:0] rf [NREGS];

    // Instruction fields are decoded from the latched word in every state.
    logic [6:0] opcode, funct7;
    logic [2:0] funct3;
    logic [4:0] rs1, rs2, rd;
    assign opcode = ir[6:0];
    assign rd     = ir[11:7];
    assign funct3 = ir[14:12];
    assign rs1    = ir[19:15];
    assign rs2    = ir[24:20];
    assign funct7 = ir[31:25];

    logic is_r, is_addi, is_lw, is_sw, is_beq, op_ok, idx_bad, legal;
    assign is_r    = (opcode == OP_R);
    assign is_addi = (opcode == OP_ADDI);
    assign is_lw   = (opcode == OP_LW);
    assign is_sw   = (opcode == OP_SW);
    assign is_beq  = (opcode == OP_BEQ);

    function automatic logic bad_idx(input logic [4:0] idx);
        return 32'(idx) >= 32'(NREGS);
    endfunction

    assign op_ok = (is_r && ((funct7 == 7'h00 && (funct3 == 3'b000 || funct3 == 3'b010 ||
                                                  funct3 == 3'b110 || funct3 == 3'b111)) ||
                             (funct7 == 7'h20 && funct3 == 3'b000)))
                || (is_addi && funct3 == 3'b000)
                || ((is_lw || is_sw) && funct3 == 3'b010)
                || (is_beq && funct3 == 3'b000);

    // Only the register fields an instruction actually uses can make it illegal.
    assign idx_bad = bad_idx(rs1)
                  || ((is_r || is_sw || is_beq) && bad_idx(rs2))
                  || ((is_r || is_addi || is_lw) && bad_idx(rd));
    assign legal   = op_ok && !idx_bad;

    logic [12:0]     imm13;
    logic [XLEN-1:0] imm_ext;
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        imm13 = {ir[31], ir[31:20]};
        if (is_sw)
            imm13 = {ir[31], ir[31:25], ir[11:7]};
        else if (is_beq)
            imm13 = {ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
    end
    assign imm_ext = {{(XLEN-13){imm13[12]}}, imm13};

    function automatic logic [XLEN-1:0] read_reg(input logic [4:0] idx);
        return (idx == 5'd0) ? '0 : rf[idx[RW-1:0]];
    endfunction

    logic [XLEN-1:0] alu;
    always_comb begin
        alu = a_q + b_q;
        if (is_addi)
            alu = a_q + imm_q;
        else begin
            case (funct3)
                3'b000:  alu = funct7[5] ? a_q - b_q : a_q + b_q;
                3'b010:  alu = {{(XLEN-1){1'b0}}, $signed(a_q) < $signed(b_q)};
                3'b110:  alu = a_q | b_q;
                3'b111:  alu = a_q & b_q;
                default: alu = a_q + b_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= FETCH;
            pc_q  <= RESET_PC;
            ir    <= '0;
            a_q   <= '0;
            b_q   <= '0;
            imm_q <= '0;
            res_q <= '0;
            // NOTE: the register file is cleared by reset, so it is built from flops rather than a RAM macro.
            for (int i = 0; i < NREGS; i++) rf[i] <= '0;
        end else begin
            case (state)
                FETCH: if (bus.mem_ack) begin
                    ir    <= bus.mem_rdata[31:0];
                    state <= DECODE;
                end
                DECODE: begin
                    a_q   <= read_reg(rs1);
                    b_q   <= read_reg(rs2);
                    imm_q <= imm_ext;
                    state <= legal ? EXEC : HALT;
                end
                EXEC: begin
                    if (is_beq) begin
                        pc_q  <= (a_q == b_q) ? pc_q + imm_q : pc_q + FOUR;
                        state <= FETCH;
                    end else if (is_lw || is_sw) begin
                        res_q <= a_q + imm_q;
                        state <= MEM;
                    end else begin
                        res_q <= alu;
                        state <= WB;
                    end
                end
                MEM: if (bus.mem_ack) begin
                    if (is_sw) begin
                        pc_q  <= pc_q + FOUR;
                        state <= FETCH;
                    end else begin
                        res_q <= bus.mem_rdata;
                        state <= WB;
                    end
                end
                WB: begin
                    if (rd != 5'd0) rf[rd[RW-1:0]] <= res_q;
                    pc_q  <= pc_q + FOUR;
                    state <= FETCH;
                end
                HALT:    state <= HALT;
                default: state <= HALT;
            endcase
        end
    end

    // Bus outputs are decoded from state and gated by rst so reset drops a request at once.
    logic            req, we;
    logic [XLEN-1:0] addr, wdata;
    always_comb begin
        req   = 1'b0;
        we    = 1'b0;
        addr  = '0;
        wdata = '0;
        if (!rst) begin
            if (state == FETCH) begin
                req  = 1'b1;
                addr = pc_q;
            end else if (state == MEM) begin
                req   = 1'b1;
                we    = is_sw;
                addr  = res_q;
                wdata = b_q;
            end
        end
    end

    assign bus.mem_req   = req;
    assign bus.mem_we    = we;
    assign bus.mem_addr  = addr;
    assign bus.mem_wdata = wdata;
    assign pc            = pc_q;
    assign halted        = (state == HALT);
endmodule
